dshot_pwm_output: RTL
=====================

// Module: dshot_pwm_output
// PURPOSE
//  Downstream of the DShot frame decoder. Consumes decoded frames: speed, command, CRC flag and a done strobe.
//  Runs the arm/failsafe policy and drives one glitch-free servo-style PWM output, 1000-1999.5 us, for a legacy ESC.
//  One clock domain. The frame strobe is already synchronous to clk.
// PARAMETERS
//  CLK_FREQ_HZ    48_000_000  system clock; must be a multiple of 2 MHz
//  PERIOD_US      2500        PWM frame period (400 Hz)
//  MIN_PULSE_US   1000        pulse width for stop/disarmed; span is fixed at 1000 us
//  TIMEOUT_MS     100         max gap between CRC-valid frames while armed
//  ARM_FRAMES     10          consecutive MOTOR_STOP frames needed to arm
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous, active-low reset
//  frame_strobe   in   1   1-cycle pulse: a decoded frame is presented on the inputs below
//  crc_valid      in   1   frame CRC matched
//  is_command     in   1   frame value < 48 (special command)
//  command        in   6   special command number (0 = MOTOR_STOP)
//  speed          in   11  throttle 0..1999 (already offset by 48)
//  pwm_out        out  1   registered PWM output
//  armed          out  1   state == ARMED
//  failsafe       out  1   state == FAILSAFE
//  crc_err_count  out  8   saturating count of frames with crc_valid=0
// BEHAVIOUR
//  Reset state: DISARMED; period counter 0; active and pending width = MIN_TICKS; arm counter 0; timeout counter 0.
//  Reset outputs: pwm_out=0, armed=0, failsafe=0, crc_err_count=0. Reset asserted mid-pulse drops pwm_out at once.
//  Derived constants: TPU = CLK_FREQ_HZ/1e6; PERIOD_TICKS = PERIOD_US*TPU; MIN_TICKS = MIN_PULSE_US*TPU.
//  Width: width = MIN_TICKS + sat1999(speed)*(TPU/2). Each speed step is 0.5 us.
//  Period counter: 0..PERIOD_TICKS-1, then wraps; it runs in every state.
//  pwm_out <= (cnt < active) && state!=FAILSAFE.
//  At cnt==PERIOD_TICKS-1: active <= pending (shadow update); no width change ever occurs mid-period.
//  "good" frame = frame_strobe & crc_valid.
//  "bad" frame = frame_strobe & !crc_valid: crc_err_count +1, saturates at 255. No other effect; does not reset the timeout.
//  DISARMED:
//   - pending = MIN_TICKS.
//   - A good MOTOR_STOP frame increments the arm counter; any other good frame clears it.
//   - When the count reaches ARM_FRAMES -> ARMED on the following cycle.
//  ARMED:
//   - Good speed frame: pending <= width(speed) one cycle after the strobe.
//   - Good MOTOR_STOP frame: pending <= MIN_TICKS. Other commands: pending unchanged.
//   - Every good frame clears the timeout counter.
//   - Counter reaching TIMEOUT_MS*1000*TPU -> FAILSAFE; pending <= MIN_TICKS.
//  FAILSAFE:
//   - pwm_out forced 0 from the next cycle.
//   - A good frame -> DISARMED and clears the arm counter. That frame does not count toward arming.
//   - MIN pulses resume at the next period boundary.
//  Simultaneous events:
//   - Good frame on the cycle the timeout expires: the frame wins and the state stays ARMED.
//   - Frame strobe on the wrap cycle: active takes the old pending; the new value applies one period later.
//  Latency: strobe at T -> pending at T+1 -> on pin at the first period start after T+1.
// STRUCTURE
//  Shared package dshot_pkg:
//   - SPEED_W=11, CMD_W=6, DSHOT_CMD_MOTOR_STOP=6'd0, DSHOT_SPEED_MAX=11'd1999
//   - output state encoding {DISARMED, ARMED, FAILSAFE}
//  Sub-module pwm_period_gen: period counter, shadow/active width registers, compare, registered output.
//  Parent holds the FSM, arm counter, timeout counter and error counter.
// TESTING (defaults: TPU=48, PERIOD_TICKS=120000, MIN_TICKS=48000, timeout=4_800_000 cycles)
//  1 Reset released, no frames
//    -> pwm_out high 48000 / low 72000 cycles, repeating; armed=0, failsafe=0.
//  2 Ten good MOTOR_STOP frames 1 ms apart -> armed=1 one cycle after the 10th strobe.
//    Repeat with 9 stops, a speed=500 frame, then 9 stops -> armed stays 0.
//  3 Armed, speed=1000 -> next full period high 72000 cycles.
//    Armed, speed=2047 -> clamped to 1999, high 95976 cycles.
//  4 Active width 72000; speed=0 frame at cnt=10000 -> current period high 72000, next period high 48000.
//    Strobe on the wrap cycle -> new width appears one period later.
//  5 Armed, frames stop -> failsafe=1 and armed=0 exactly 4_800_000 cycles after the last good strobe; pwm_out=0.
//    Next good frame -> DISARMED, failsafe=0, 48000-cycle pulses from the next period.
//  6 300 bad-CRC frames while armed -> crc_err_count=255 (saturated); width unchanged.
//    With no good frames, bad frames do not prevent failsafe.
//    rst_n asserted mid-pulse -> pwm_out=0 asynchronously; all counters are zero after release.

Source files
------------

// File: rtl/dshot_pkg.sv
// dshot_pkg: frame field widths, command codes, FSM state encoding
// and the throttle clamp shared by the DShot PWM output slice.
package dshot_pkg;

  localparam int SPEED_W = 11;
  localparam int CMD_W   = 6;

  localparam logic [CMD_W-1:0] DSHOT_CMD_MOTOR_STOP = 6'd0;
  localparam logic [SPEED_W-1:0] DSHOT_SPEED_MAX = 11'd1999;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    FAILSAFE = 2'd2
  } dshot_state_e;

  function automatic logic [SPEED_W-1:0] sat_speed(
    input logic [SPEED_W-1:0] s
  );
    return (s > DSHOT_SPEED_MAX) ? DSHOT_SPEED_MAX : s;
  endfunction

endpackage

// File: rtl/dshot_pwm_output_if.sv
// dshot_pwm_output_if: decoded-frame bundle from the DShot decoder.
// master drives strobe/crc/is_command/command/speed; slave consumes.
interface dshot_pwm_output_if;
  import dshot_pkg::*;

  logic               frame_strobe;
  logic               crc_valid;
  logic               is_command;
  logic [CMD_W-1:0]   command;
  logic [SPEED_W-1:0] speed;

  modport master (
    output frame_strobe,
    output crc_valid,
    output is_command,
    output command,
    output speed
  );

  modport slave (
    input frame_strobe,
    input crc_valid,
    input is_command,
    input command,
    input speed
  );

endinterface

// File: rtl/pwm_period_gen.sv
// pwm_period_gen: free-running period counter, shadow/active width,
// ports: clk, rst_n, pend_load/pend_val, force_off -> pwm_out.
module pwm_period_gen #(
  parameter int PERIOD_TICKS = 120000,
  parameter int MIN_TICKS    = 48000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pend_load,
  input  logic [$clog2(PERIOD_TICKS)-1:0] pend_val,
  input  logic                            force_off,
  output logic                            pwm_out
);

  localparam int CW = $clog2(PERIOD_TICKS);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_TICKS - 1);
  localparam logic [CW-1:0] MINW = CW'(MIN_TICKS);

  logic [CW-1:0] cnt;
  logic [CW-1:0] active;
  logic [CW-1:0] pending;
  logic          wrap;
  logic          hold;

  assign wrap = (cnt == LAST);

  // hold keeps the pin low for the rest of any period that saw
  // force_off, so leaving failsafe never starts a runt pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      active  <= MINW;
      pending <= MINW;
      hold    <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (pend_load) pending <= pend_val;
      if (wrap) active <= pending;
      hold <= wrap ? force_off : (hold | force_off);
      pwm_out <= (cnt < active) && !force_off && !hold;
    end
  end

endmodule

// File: rtl/dshot_pwm_output.sv
// dshot_pwm_output: arm/failsafe policy and servo PWM for a legacy ESC.
// ports: clk, rst_n, fin (frames), pwm_out, armed, failsafe, crc_err_count.
module dshot_pwm_output
  import dshot_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 48_000_000,
  parameter int PERIOD_US    = 2500,
  parameter int MIN_PULSE_US = 1000,
  parameter int TIMEOUT_MS   = 100,
  parameter int ARM_FRAMES   = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dshot_pwm_output_if.slave        fin,
  output logic                     pwm_out,
  output logic                     armed,
  output logic                     failsafe,
  output logic [7:0]               crc_err_count
);

  localparam int TPU          = CLK_FREQ_HZ / 1_000_000;
  localparam int PERIOD_TICKS = PERIOD_US * TPU;
  localparam int MIN_TICKS    = MIN_PULSE_US * TPU;
  localparam int TO_TICKS     = TIMEOUT_MS * 1000 * TPU;
  localparam int CW = $clog2(PERIOD_TICKS);
  localparam int TW = $clog2(TO_TICKS + 1);
  localparam int AW = $clog2(ARM_FRAMES + 1);

  localparam logic [CW-1:0] MINW = CW'(MIN_TICKS);
  localparam logic [CW-1:0] STEP = CW'(TPU / 2);

  dshot_state_e  state;
  dshot_state_e  state_nx;
  logic [AW-1:0] arm_cnt;
  logic [AW-1:0] arm_cnt_nx;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_nx;

  logic          good;
  logic          bad;
  logic          stop;
  logic          expire;
  logic [CW-1:0] width;
  logic          pend_load;
  logic [CW-1:0] pend_val;

  assign good = fin.frame_strobe & fin.crc_valid;
  assign bad  = fin.frame_strobe & ~fin.crc_valid;
  assign stop = fin.is_command &
                (fin.command == DSHOT_CMD_MOTOR_STOP);

  // to_cnt holds cycles elapsed since the last good frame
  assign expire = (to_cnt == TW'(TO_TICKS - 1));

  assign width = MINW + CW'(sat_speed(fin.speed)) * STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DISARMED;
      arm_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nx;
      arm_cnt <= arm_cnt_nx;
      to_cnt  <= to_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    arm_cnt_nx = arm_cnt;
    to_cnt_nx  = '0;
    pend_load  = 1'b0;
    pend_val   = MINW;
    unique case (state)
      DISARMED: begin
        pend_load = 1'b1;
        if (good) begin
          if (!stop) begin
            arm_cnt_nx = '0;
          end else if (arm_cnt == AW'(ARM_FRAMES - 1)) begin
            state_nx   = ARMED;
            arm_cnt_nx = '0;
            to_cnt_nx  = TW'(1);
          end else begin
            arm_cnt_nx = arm_cnt + AW'(1);
          end
        end
      end
      ARMED: begin
        if (good) begin
          // a good frame beats a timeout on the same cycle
          to_cnt_nx = TW'(1);
          if (!fin.is_command) begin
            pend_load = 1'b1;
            pend_val  = width;
          end else if (stop) begin
            pend_load = 1'b1;
          end
        end else if (expire) begin
          state_nx  = FAILSAFE;
          pend_load = 1'b1;
        end else begin
          to_cnt_nx = to_cnt + TW'(1);
        end
      end
      FAILSAFE: begin
        pend_load = 1'b1;
        if (good) begin
          state_nx   = DISARMED;
          arm_cnt_nx = '0;
        end
      end
      default: begin
        state_nx = DISARMED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_err_count <= '0;
    end else if (bad && crc_err_count != 8'hFF) begin
      crc_err_count <= crc_err_count + 8'd1;
    end
  end

  assign armed    = (state == ARMED);
  assign failsafe = (state == FAILSAFE);

  pwm_period_gen #(
    .PERIOD_TICKS (PERIOD_TICKS),
    .MIN_TICKS    (MIN_TICKS)
  ) u_pwm (
    .clk       (clk),
    .rst_n     (rst_n),
    .pend_load (pend_load),
    .pend_val  (pend_val),
    .force_off (failsafe),
    .pwm_out   (pwm_out)
  );

endmodule
